// File: rtl/aes_pkg.sv
// Shared AES definitions for the cipher core and the key expansion block.
// Contents:
//   AES_NR / AES_NK / AES_BLK : rounds, key words, block width
//   aes_state_e               : cipher core FSM encoding
//   sbox()                    : forward S-box (the single table in the design)
//   xtime()                   : multiply by x in GF(2^8); MSB is index 0
package aes_pkg;

  localparam int AES_NR  = 10;
  localparam int AES_NK  = 4;
  localparam int AES_BLK = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } aes_state_e;

  // Forward S-box, entry 0 in the leftmost byte.
  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX_TBL[{a, 3'b000} +: 8];
  endfunction

  function automatic logic [0:7] xtime(input logic [0:7] a);
    return {a[1:7], 1'b0} ^ (a[0] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round.sv
// One AES encryption round, purely combinational.
// Ports:
//   state       : round input block (byte 0 = bits [0:7], column-major)
//   round_key   : key added at the end of the round
//   final_round : skip MixColumns (last round)
//   next_state  : round output block
module aes_round
  import aes_pkg::*;
(
  input  logic [0:AES_BLK-1] state,
  input  logic [0:AES_BLK-1] round_key,
  input  logic               final_round,
  output logic [0:AES_BLK-1] next_state
);

  logic [7:0] sb_s [16];
  logic [7:0] sr_s [16];
  logic [7:0] mc_s [16];

  // SubBytes: one table lookup per byte
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      sb_s[i] = sbox(state[8*i +: 8]);
    end
  end

  // ShiftRows: byte (row r, column c) comes from column (c + r) mod 4
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_s[4*c + r] = sb_s[4*((c + r) % 4) + r];
      end
    end
  end

  // MixColumns: 3*a expressed as xtime(a) ^ a
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      mc_s[4*c + 0] = xtime(sr_s[4*c]) ^ xtime(sr_s[4*c + 1]) ^ sr_s[4*c + 1]
                    ^ sr_s[4*c + 2] ^ sr_s[4*c + 3];
      mc_s[4*c + 1] = sr_s[4*c] ^ xtime(sr_s[4*c + 1]) ^ xtime(sr_s[4*c + 2])
                    ^ sr_s[4*c + 2] ^ sr_s[4*c + 3];
      mc_s[4*c + 2] = sr_s[4*c] ^ sr_s[4*c + 1] ^ xtime(sr_s[4*c + 2])
                    ^ xtime(sr_s[4*c + 3]) ^ sr_s[4*c + 3];
      mc_s[4*c + 3] = xtime(sr_s[4*c]) ^ sr_s[4*c] ^ sr_s[4*c + 1]
                    ^ sr_s[4*c + 2] ^ xtime(sr_s[4*c + 3]);
    end
  end

  // AddRoundKey, bypassing MixColumns in the final round
  always_comb begin
    next_state = '0;
    for (int i = 0; i < 16; i++) begin
      next_state[8*i +: 8] = (final_round ? sr_s[i] : mc_s[i]) ^ round_key[8*i +: 8];
    end
  end

endmodule

// File: rtl/aes128_cipher_core.sv
// Iterative AES-128 encryption core: initial AddRoundKey on acceptance, then
// one round per clock, result held until the downstream handshake.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : plaintext + round_keys handshake
//   plaintext            : input block, byte 0 = bits [0:7]
//   round_keys           : 44-word expanded key, round r at [r*128 +: 128];
//                          not registered, must stay stable through the last round
//   out_valid / out_ready: ciphertext handshake
//   ciphertext           : result, zero whenever out_valid is low
//   busy                 : block accepted and not yet handed off
module aes128_cipher_core
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [0:AES_BLK-1]               plaintext,
  input  logic [0:(NR+1)*AES_NK*32-1]      round_keys,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [0:AES_BLK-1]               ciphertext,
  output logic                             busy
);

  if (NR != AES_NR) begin : g_bad_nr
    $error("aes128_cipher_core: NR must be %0d", AES_NR);
  end

  aes_state_e        state_r, state_nxt_s;
  logic [3:0]        rnd_r, rnd_nxt_s;
  logic [0:AES_BLK-1] blk_r, blk_nxt_s;
  logic [0:AES_BLK-1] rk_s, round_out_s;
  logic              final_s;
  logic              in_ready_nxt_s, out_valid_nxt_s, busy_nxt_s;
  logic [0:AES_BLK-1] ciphertext_nxt_s;

  // A corrupted counter above NR still ends the block instead of running on.
  assign final_s = (rnd_r >= 4'(NR));
  assign rk_s    = round_keys[{rnd_r, 7'd0} +: AES_BLK];

  aes_round u_round (
    .state       (blk_r),
    .round_key   (rk_s),
    .final_round (final_s),
    .next_state  (round_out_s)
  );

  // Next-state, datapath and next-output decode
  always_comb begin
    state_nxt_s = state_r;
    rnd_nxt_s   = rnd_r;
    blk_nxt_s   = blk_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          state_nxt_s = ST_RUN;
          blk_nxt_s   = plaintext ^ round_keys[0 +: AES_BLK];
          rnd_nxt_s   = 4'd1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        blk_nxt_s = round_out_s;
        if (final_s) begin
          state_nxt_s = ST_DONE;
          rnd_nxt_s   = 4'd0;
        end else begin
          rnd_nxt_s = rnd_r + 4'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        rnd_nxt_s   = 4'd0;
        blk_nxt_s   = '0;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    in_ready_nxt_s   = (state_nxt_s == ST_IDLE);
    out_valid_nxt_s  = (state_nxt_s == ST_DONE);
    busy_nxt_s       = (state_nxt_s != ST_IDLE);
    ciphertext_nxt_s = (state_nxt_s == ST_DONE) ? blk_nxt_s : '0;
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      rnd_r      <= 4'd0;
      blk_r      <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      ciphertext <= '0;
    end else begin
      state_r    <= state_nxt_s;
      rnd_r      <= rnd_nxt_s;
      blk_r      <= blk_nxt_s;
      in_ready   <= in_ready_nxt_s;
      out_valid  <= out_valid_nxt_s;
      busy       <= busy_nxt_s;
      ciphertext <= ciphertext_nxt_s;
    end
  end

endmodule
